// File: rtl/proto_sel_pkg.sv
// Shared types and constants for the protocol channel-select controller.
package proto_sel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } sel_state_t;

  // Bit positions inside the registered host pulse vector
  localparam int PLS_ACK  = 0;
  localparam int PLS_ERR  = 1;
  localparam int PLS_DONE = 2;
  localparam int PLS_TMO  = 3;
  localparam int NUM_PLS  = 4;

  function automatic int sel_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/protocol_select_ctrl_if.sv
// Host/engine-facing signal bundle of the channel-select controller.
interface protocol_select_ctrl_if #(
  parameter int NUM_CH = 3,
  parameter int MODE_W = 2,
  parameter int TMO_W  = 16
);
  logic [MODE_W-1:0] mode;
  logic              mode_req;
  logic [NUM_CH-1:0] ch_reset;
  logic [NUM_CH-1:0] ch_busy;
  logic [NUM_CH-1:0] ch_valid;
  logic [TMO_W-1:0]  tmo_limit;
  logic [NUM_CH-1:0] select;
  logic [MODE_W-1:0] active_ch;
  logic              bound;
  logic              mode_ack;
  logic              mode_err;
  logic              done;
  logic              tmo_err;
  logic [1:0]        state;

  modport master (
    output mode, mode_req, ch_reset, ch_busy, ch_valid, tmo_limit,
    input  select, active_ch, bound, mode_ack, mode_err, done, tmo_err, state
  );

  modport slave (
    input  mode, mode_req, ch_reset, ch_busy, ch_valid, tmo_limit,
    output select, active_ch, bound, mode_ack, mode_err, done, tmo_err, state
  );
endinterface

// File: rtl/sel_watchdog.sv
// Busy watchdog: counts busy cycles of the bound transfer, flags the limit.
module sel_watchdog #(
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [TMO_W-1:0] limit,
  output logic             expire
);
  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (inc && cnt != '1)
      cnt <= cnt + TMO_W'(1);
  end

  // A limit of zero disables the watchdog entirely
  assign expire = (limit != '0) && (cnt == limit - TMO_W'(1));

endmodule

// File: rtl/protocol_select_ctrl.sv
// Binds one protocol engine as the active channel and drives the pin-mux select.
module protocol_select_ctrl
  import proto_sel_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int MODE_W = sel_clog2(NUM_CH),
  parameter int TMO_W  = 16
) (
  input logic                   clk,
  input logic                   reset,
  protocol_select_ctrl_if.slave bus
);
  sel_state_t          state_q, state_n;
  logic [MODE_W-1:0]   ch_q, ch_n;
  logic [NUM_CH-1:0]   sel_q, sel_n;
  logic [NUM_PLS-1:0]  pls_q, pls_n;
  logic                wd_clr, wd_inc, wd_exp;
  logic                mode_ok, c_rst, c_busy, c_valid;

  assign mode_ok = {1'b0, bus.mode} < (MODE_W+1)'(NUM_CH);
  assign c_rst   = bus.ch_reset[ch_q];
  assign c_busy  = bus.ch_busy[ch_q];
  assign c_valid = bus.ch_valid[ch_q];

  sel_watchdog #(.TMO_W(TMO_W)) u_wd (
    .clk    (clk),
    .reset  (reset),
    .clr    (wd_clr),
    .inc    (wd_inc),
    .limit  (bus.tmo_limit),
    .expire (wd_exp)
  );

  always_comb begin
    state_n = state_q;
    ch_n    = ch_q;
    pls_n   = '0;
    wd_clr  = 1'b0;
    wd_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mode_req) begin
          if (mode_ok) begin
            ch_n           = bus.mode;
            pls_n[PLS_ACK] = 1'b1;
            state_n        = ARMED;
          end else begin
            pls_n[PLS_ERR] = 1'b1;
          end
        end
      end
      ARMED: begin
        if (bus.mode_req) begin
          if (mode_ok) begin
            ch_n           = bus.mode;
            pls_n[PLS_ACK] = 1'b1;
          end else begin
            pls_n[PLS_ERR] = 1'b1;
          end
        end else if (!c_rst && c_busy) begin
          state_n = ACTIVE;
          wd_clr  = 1'b1;
        end
      end
      ACTIVE: begin
        // Rebinding mid-transfer is refused, the transfer itself carries on
        pls_n[PLS_ERR] = bus.mode_req;
        if (c_rst) begin
          state_n = ARMED;
        end else if (c_busy) begin
          if (wd_exp) begin
            pls_n[PLS_TMO] = 1'b1;
            state_n        = ARMED;
          end else begin
            wd_inc = 1'b1;
          end
        end else if (c_valid) begin
          pls_n[PLS_DONE] = 1'b1;
          state_n         = ARMED;
        end
      end
      default: state_n = IDLE;
    endcase
    sel_n = (state_n == ACTIVE) ? (NUM_CH'(1) << ch_n) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      sel_q   <= '0;
      pls_q   <= '0;
    end else begin
      state_q <= state_n;
      ch_q    <= ch_n;
      sel_q   <= sel_n;
      pls_q   <= pls_n;
    end
  end

  assign bus.select    = sel_q;
  assign bus.active_ch = ch_q;
  assign bus.bound     = (state_q != IDLE);
  assign bus.mode_ack  = pls_q[PLS_ACK];
  assign bus.mode_err  = pls_q[PLS_ERR];
  assign bus.done      = pls_q[PLS_DONE];
  assign bus.tmo_err   = pls_q[PLS_TMO];
  assign bus.state     = state_q;

endmodule

// File: tb/tb_protocol_select_ctrl.sv
// Scoreboard bench: 3- and 5-channel controllers driven in lockstep against a reference model.
module tb_protocol_select_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  protocol_select_ctrl_if #(.NUM_CH(3), .MODE_W(2), .TMO_W(16)) b3 ();
  protocol_select_ctrl_if #(.NUM_CH(5), .MODE_W(3), .TMO_W(16)) b5 ();

  protocol_select_ctrl #(.NUM_CH(3), .MODE_W(2), .TMO_W(16)) dut3 (
    .clk(clk), .reset(reset), .bus(b3.slave));
  protocol_select_ctrl #(.NUM_CH(5), .MODE_W(3), .TMO_W(16)) dut5 (
    .clk(clk), .reset(reset), .bus(b5.slave));

  int checks = 0;
  int failures = 0;

  // Expected word: {select[4:0], active_ch[2:0], bound, ack, err, done, tmo, state[1:0]}
  logic [14:0] q0[$];
  logic [14:0] q1[$];

  bit m_bound[2];
  bit m_fl[2];
  int m_ch[2];
  int m_run[2];

  task automatic model_step(input int i, input int nc, input bit rst, input int mode,
                            input bit req, input logic [4:0] cr, input logic [4:0] cb,
                            input logic [4:0] cv, input int lim, output logic [14:0] e);
    bit ack, err, dn, tmo;
    logic [4:0] sel;
    int st;
    ack = 0; err = 0; dn = 0; tmo = 0;
    if (rst) begin
      m_bound[i] = 0; m_fl[i] = 0; m_ch[i] = 0; m_run[i] = 0;
    end else if (!m_bound[i]) begin
      if (req) begin
        if (mode < nc) begin ack = 1; m_ch[i] = mode; m_bound[i] = 1; end
        else err = 1;
      end
    end else if (!m_fl[i]) begin
      if (req) begin
        if (mode < nc) begin ack = 1; m_ch[i] = mode; end
        else err = 1;
      end else if (!cr[m_ch[i]] && cb[m_ch[i]]) begin
        m_fl[i] = 1; m_run[i] = 0;
      end
    end else begin
      err = req;
      if (cr[m_ch[i]]) m_fl[i] = 0;
      else if (cb[m_ch[i]]) begin
        m_run[i]++;
        if (lim != 0 && m_run[i] == lim) begin tmo = 1; m_fl[i] = 0; end
      end else if (cv[m_ch[i]]) begin
        dn = 1; m_fl[i] = 0;
      end
    end
    sel = m_fl[i] ? 5'(1 << m_ch[i]) : 5'd0;
    st  = !m_bound[i] ? 0 : (m_fl[i] ? 2 : 1);
    e = {sel, 3'(m_ch[i]), m_bound[i], ack, err, dn, tmo, 2'(st)};
  endtask

  task automatic drive(input bit rst, input int mode, input bit req, input logic [4:0] cr,
                       input logic [4:0] cb, input logic [4:0] cv, input int lim);
    logic [14:0] e0, e1;
    @(negedge clk);
    reset = rst;
    b3.mode = 2'(mode); b3.mode_req = req; b3.ch_reset = cr[2:0];
    b3.ch_busy = cb[2:0]; b3.ch_valid = cv[2:0]; b3.tmo_limit = 16'(lim);
    b5.mode = 3'(mode); b5.mode_req = req; b5.ch_reset = cr;
    b5.ch_busy = cb; b5.ch_valid = cv; b5.tmo_limit = 16'(lim);
    model_step(0, 3, rst, mode & 3, req, cr, cb, cv, lim, e0);
    model_step(1, 5, rst, mode & 7, req, cr, cb, cv, lim, e1);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic idle(input int n, input int lim);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 5'd0, 5'd0, 5'd0, lim);
  endtask

  task automatic cmp(input string name, input logic [14:0] a, input logic [14:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s t=%0t got sel=%b ch=%0d bound=%b ack/err/done/tmo=%b state=%0d, expected sel=%b ch=%0d bound=%b ack/err/done/tmo=%b state=%0d",
               name, $time, a[14:10], a[9:7], a[6], a[5:2], a[1:0],
               e[14:10], e[9:7], e[6], e[5:2], e[1:0]);
    end
  endtask

  // Monitor: compares every registered output cycle against the queued expectation
  initial begin
    logic [14:0] a;
    forever begin
      @(posedge clk);
      #2;
      if (q0.size() != 0) begin
        a = {2'b00, b3.select, 1'b0, b3.active_ch, b3.bound, b3.mode_ack, b3.mode_err,
             b3.done, b3.tmo_err, b3.state};
        cmp("dut3_outputs", a, q0.pop_front());
      end
      if (q1.size() != 0) begin
        a = {b5.select, b5.active_ch, b5.bound, b5.mode_ack, b5.mode_err,
             b5.done, b5.tmo_err, b5.state};
        cmp("dut5_outputs", a, q1.pop_front());
      end
    end
  end

  initial begin
    logic [4:0] busy, cv, cr;
    int lim, mode;
    bit rst, req;
    reset = 1'b1;
    b3.mode = '0; b3.mode_req = 0; b3.ch_reset = '0; b3.ch_busy = '0; b3.ch_valid = '0; b3.tmo_limit = '0;
    b5.mode = '0; b5.mode_req = 0; b5.ch_reset = '0; b5.ch_busy = '0; b5.ch_valid = '0; b5.tmo_limit = '0;

    drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    drive(0, 7, 1, 5'd0, 5'd0, 5'd0, 0);          // invalid mode in IDLE
    drive(0, 1, 1, 5'd0, 5'd0, 5'd0, 0);          // bind ch1
    idle(1, 0);
    for (int k = 0; k < 4; k++)                   // busy on ch1, neighbours toggle
      drive(0, 0, 0, 5'd0, (k % 2 == 1) ? 5'b10111 : 5'b00010, 5'b00101, 0);
    drive(0, 0, 0, 5'd0, 5'd0, 5'b00010, 0);      // done
    idle(2, 0);

    drive(0, 2, 1, 5'd0, 5'd0, 5'd0, 5);          // watchdog limit 5 on ch2
    for (int k = 0; k < 8; k++) drive(0, 0, 0, 5'd0, 5'b00100, 5'd0, 5);
    drive(0, 0, 0, 5'd0, 5'd0, 5'b00100, 5);
    idle(1, 1);
    drive(0, 0, 0, 5'd0, 5'b00100, 5'd0, 1);      // limit 1
    drive(0, 0, 0, 5'd0, 5'b00100, 5'd0, 1);
    drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    for (int k = 0; k < 100; k++) drive(0, 0, 0, 5'd0, 5'b00100, 5'd0, 0);
    drive(0, 0, 0, 5'd0, 5'd0, 5'b00100, 0);

    drive(0, 1, 1, 5'd0, 5'd0, 5'd0, 0);          // rebind ch1, then refuse switch mid-transfer
    drive(0, 0, 0, 5'd0, 5'b00010, 5'd0, 0);
    drive(0, 0, 1, 5'd0, 5'b00010, 5'b00010, 0);
    drive(0, 3, 1, 5'd0, 5'd0, 5'd0, 0);
    drive(0, 0, 0, 5'd0, 5'd0, 5'b00010, 0);
    drive(0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
    drive(0, 3, 1, 5'd0, 5'd0, 5'd0, 0);
    drive(0, 7, 1, 5'd0, 5'd0, 5'd0, 0);

    drive(0, 1, 1, 5'd0, 5'd0, 5'd0, 0);          // channel abort mid-transfer
    drive(0, 0, 0, 5'd0, 5'b00010, 5'd0, 0);
    drive(0, 0, 0, 5'd0, 5'b00010, 5'd0, 0);
    drive(0, 0, 0, 5'b00010, 5'b00010, 5'b00010, 0);
    drive(0, 0, 0, 5'd0, 5'b00010, 5'd0, 0);
    drive(1, 0, 0, 5'd0, 5'b00010, 5'b00010, 0);  // block reset during ACTIVE
    idle(1, 0);

    drive(0, 4, 1, 5'd0, 5'd0, 5'd0, 0);          // ch4 on the 5-channel build
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 5'd0, 5'b10001, 5'd0, 0);
    drive(0, 0, 0, 5'd0, 5'd0, 5'b10001, 0);
    idle(1, 0);

    busy = '0; lim = 3;
    for (int n = 0; n < 2500; n++) begin
      if (n % 60 == 0) begin
        case ($urandom_range(0, 5))
          0: lim = 0; 1: lim = 1; 2: lim = 2; 3: lim = 3; 4: lim = 5; default: lim = 8;
        endcase
      end
      for (int b = 0; b < 5; b++) begin
        if ($urandom_range(0, 4) == 0) busy[b] = ~busy[b];
        cr[b] = ($urandom_range(0, 19) == 0);
        cv[b] = ($urandom_range(0, 2) == 0);
      end
      rst  = ($urandom_range(0, 79) == 0);
      req  = ($urandom_range(0, 5) == 0);
      mode = int'($urandom_range(0, 7));
      drive(rst, mode, req, cr, busy, cv, lim);
    end

    idle(1, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d/%0d expected 0/0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
